evt_burst_stepper: RTL and testbench
====================================

// Module: evt_burst_stepper
// PURPOSE
//  Multi-channel, parametrised event/value stepper for the MAC verification stimulus path.
//  Each channel holds a VAL_W-bit value, an even-parity flag and a saturating trigger counter.
//  A command either performs one step on a channel or a burst of steps with programmable idle gaps.
//  Every step emits a one-cycle event pulse that scoreboards and monitors count.
// PARAMETERS
//  NCH    4   number of channels (>=1)
//  VAL_W  8   per-channel value width
//  CNT_W  16  per-channel trigger-counter width
//  LEN_W  4   burst-length field width
//  GAP_W  3   inter-step gap field width
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous reset, active-high
//  cmd_valid  in   1            command present
//  cmd_ready  out  1            command accepted when cmd_valid & cmd_ready at clk edge
//  cmd_ch     in   CH_W         target channel, CH_W = max(1,$clog2(NCH))
//  cmd_burst  in   1            0 = single step, 1 = burst of cmd_len steps
//  cmd_len    in   LEN_W        burst step count (ignored when cmd_burst=0)
//  cmd_gap    in   GAP_W        idle cycles between consecutive burst steps
//  cnt_clr    in   1            synchronous clear of all trigger counters
//  val        out  NCH*VAL_W    channel values, channel i at [i*VAL_W +: VAL_W]
//  flag       out  NCH          1 when the channel value is even (~val_i[0])
//  evt        out  NCH          one-cycle pulse per step on the stepped channel
//  trig_cnt   out  NCH*CNT_W    per-channel step counts, channel i at [i*CNT_W +: CNT_W]
//  busy       out  1            command in progress (state != IDLE)
//  done       out  1            one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, val=0, flag=all 1, evt=0, trig_cnt=0, busy=0, done=0, cmd_ready=1.
//   Reset mid-burst drops the command. No further evt is produced for it.
//  All outputs are registered. cmd_ready = (state==IDLE). cmd_* are captured at the accept edge.
//  cmd_ch >= NCH: the command is accepted and completes with done only. No val/evt/trig_cnt change.
//  FSM: IDLE -> STEP on accept (single, or burst with len>=1).
//       IDLE -> FIN on accept of a burst with cmd_len=0.
//       STEP -> GAP if steps remain and gap>0. STEP -> STEP if steps remain and gap=0.
//       STEP -> IDLE after the last step.
//       GAP counts down gap cycles, then -> STEP.
//       FIN -> IDLE. done=1 is visible the cycle after FIN is entered.
//  Step: the edge that ends a STEP cycle does the following on channel ch:
//   - val_ch <= val_ch+1, modulo 2^VAL_W (0xFF -> 0x00 for VAL_W=8).
//   - flag_ch <= ~new_val[0].
//   - evt_ch <= 1 for exactly one cycle.
//   - trig_cnt_ch <= trig_cnt_ch+1, saturating at 2^CNT_W-1.
//   All of these are visible in the same cycle.
//  Latency: accept at edge k -> first updated val/evt visible after edge k+1.
//   Burst steps are spaced gap+1 cycles apart. No gap is inserted after the last step.
//  done pulses in the same cycle as the final evt. busy drops in that same cycle.
//   A new command may be accepted at the edge that ends that cycle.
//  Other channels hold val and flag, and keep evt=0.
//  cnt_clr takes precedence over counting. Concurrent with a step, the stepped channel's count becomes 1; all others become 0.
//   cnt_clr does not affect val, flag or the FSM.
//  cmd_valid while busy has no effect. The command is held by the source until cmd_ready.
// TESTING
//  T1 reset, single step ch0 x3 -> val0 1,2,3; flag0 0,1,0; 3 evt0 pulses; trig_cnt0=3; done each time
//  T2 burst ch2 len=10 gap=4 from val=0 -> 10 evt2 pulses spaced 5 cycles; val2=10; flag2=1; done with 10th evt
//  T3 val1=0xFE, burst len=3 gap=0 -> val1 0xFF,0x00,0x01 on consecutive cycles; flag 0,1,0
//  T4 CNT_W=4: 20 single steps ch3 -> trig_cnt3 sticks at 15; val3=20
//  T5 cnt_clr coincident with a step on ch1 (counts 5,7) -> ch1=1, others=0
//  T6 assert rst midway through burst len=8 -> all outputs at reset values; burst aborted; cmd_ready=1 after release; burst len=0 -> done only

Source files
------------

// File: rtl/evt_burst_stepper_if.sv
// Command bus for evt_burst_stepper: valid/ready handshake plus command fields.
// Latency: none (wires only).
// Backpressure: the source holds cmd_* stable while cmd_valid=1 and cmd_ready=0.
// Ports: cmd_valid/cmd_ready handshake, cmd_ch target channel, cmd_burst mode,
//        cmd_len burst step count, cmd_gap idle cycles between burst steps.
interface evt_burst_stepper_if #(
    parameter int CH_W  = 2,
    parameter int LEN_W = 4,
    parameter int GAP_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic             cmd_burst;
    logic [LEN_W-1:0] cmd_len;
    logic [GAP_W-1:0] cmd_gap;

    modport master (
        output cmd_valid, cmd_ch, cmd_burst, cmd_len, cmd_gap,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_burst, cmd_len, cmd_gap,
        output cmd_ready
    );
endinterface

// File: rtl/evt_burst_stepper.sv
// Multi-channel value stepper: single steps or bursts with idle gaps, one evt pulse per step.
// Latency: accept at edge k, first val/evt update visible after edge k+1; bursts spaced gap+1 cycles.
// Backpressure: cmd_ready=1 only in IDLE; commands offered while busy are ignored.
// Ports: clk/rst (async, active-high); cmd_if command bus (slave); i_cnt_clr clears all
//        trigger counters; o_val/o_flag/o_evt/o_trig_cnt per-channel state; o_busy/o_done status.
module evt_burst_stepper #(
    parameter int NCH   = 4,
    parameter int VAL_W = 8,
    parameter int CNT_W = 16,
    parameter int LEN_W = 4,
    parameter int GAP_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    evt_burst_stepper_if.slave     cmd_if,
    input  logic                   i_cnt_clr,
    output logic [NCH*VAL_W-1:0]   o_val,
    output logic [NCH-1:0]         o_flag,
    output logic [NCH-1:0]         o_evt,
    output logic [NCH*CNT_W-1:0]   o_trig_cnt,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CH_W:0]    NCH_L   = (CH_W+1)'(NCH);
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [VAL_W-1:0] VAL_ONE = {{(VAL_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                       r_state;
    logic [CH_W-1:0]              r_ch;
    logic [LEN_W-1:0]             r_left;     // steps still to issue, including the current STEP
    logic [GAP_W-1:0]             r_gap;
    logic [GAP_W-1:0]             r_gap_cnt;
    logic                         r_ready;
    logic                         r_busy;
    logic                         r_done;

    logic [NCH-1:0][VAL_W-1:0]    r_val;
    logic [NCH-1:0]               r_flag;
    logic [NCH-1:0]               r_evt;
    logic [NCH-1:0][CNT_W-1:0]    r_cnt;

    logic                         w_ch_ok;
    logic                         w_step;
    logic [NCH-1:0]               w_sel;

    // Out-of-range channels are accepted but routed straight to FIN, so STEP never sees them.
    assign w_ch_ok = ({1'b0, cmd_if.cmd_ch} < NCH_L);
    assign w_step  = (r_state == S_STEP);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_ch == CH_W'(i)) begin
                w_sel[i] = 1'b1;
            end
        end
    end

    // Control FSM; status outputs are registered alongside the state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_left    <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_if.cmd_valid) begin
                        r_ch    <= cmd_if.cmd_ch;
                        r_gap   <= cmd_if.cmd_gap;
                        r_left  <= cmd_if.cmd_burst ? cmd_if.cmd_len : LEN_ONE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (!w_ch_ok || (cmd_if.cmd_burst && (cmd_if.cmd_len == '0))) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    if (r_left == LEN_ONE) begin
                        // Last step: done and the idle status land together with the final evt.
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_left <= r_left - LEN_ONE;
                        if (r_gap != '0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= r_gap;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_ONE) begin
                        r_state <= S_STEP;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_ONE;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-channel datapath: the edge that ends a STEP cycle updates the selected channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val  <= '0;
            r_flag <= '1;
            r_evt  <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_evt[i] <= 1'b0;
                if (w_step && w_sel[i]) begin
                    r_val[i]  <= r_val[i] + VAL_ONE;
                    // The incremented value's LSB is the inverse of the old LSB, so
                    // "new value is even" equals the old LSB.
                    r_flag[i] <= r_val[i][0];
                    r_evt[i]  <= 1'b1;
                end
                // Clear wins over counting; a step coinciding with the clear counts once.
                if (i_cnt_clr) begin
                    r_cnt[i] <= (w_step && w_sel[i]) ? CNT_ONE : '0;
                end else if (w_step && w_sel[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign cmd_if.cmd_ready = r_ready;
    assign o_val            = r_val;
    assign o_flag           = r_flag;
    assign o_evt            = r_evt;
    assign o_trig_cnt       = r_cnt;
    assign o_busy           = r_busy;
    assign o_done           = r_done;

endmodule

// File: tb/tb_evt_burst_stepper.sv
// Testbench for evt_burst_stepper (NCH=4, VAL_W=8, CNT_W=4 so counter saturation is reachable).
// Expected values come from a per-channel arithmetic model plus a command schedule
// (steps at accept+1+j*(gap+1), done with the last step) and hand-computed constants.
module tb_evt_burst_stepper;
    localparam int NCH   = 4;
    localparam int VAL_W = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = 4;
    localparam int GAP_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                 clk;
    logic                 rst;
    logic                 i_cnt_clr;
    logic [NCH*VAL_W-1:0] o_val;
    logic [NCH-1:0]       o_flag;
    logic [NCH-1:0]       o_evt;
    logic [NCH*CNT_W-1:0] o_trig_cnt;
    logic                 o_busy;
    logic                 o_done;

    evt_burst_stepper_if #(.CH_W(2), .LEN_W(LEN_W), .GAP_W(GAP_W)) cmd_if ();

    evt_burst_stepper #(
        .NCH(NCH), .VAL_W(VAL_W), .CNT_W(CNT_W), .LEN_W(LEN_W), .GAP_W(GAP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_if     (cmd_if.slave),
        .i_cnt_clr  (i_cnt_clr),
        .o_val      (o_val),
        .o_flag     (o_flag),
        .o_evt      (o_evt),
        .o_trig_cnt (o_trig_cnt),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain per-channel value and count.
    int mval [NCH];
    int mcnt [NCH];

    // Observations of the commanded channel on each evt during the last run_cmd.
    int obs_e    [$];
    int obs_val  [$];
    int obs_flag [$];

    typedef struct {
        int ch;
        bit burst;
        int len;
        int gap;
        int exp_val;
        int exp_flag;
        int exp_cnt;
        int exp_nevt;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mval[i] = 0;
            mcnt[i] = 0;
        end
    endtask

    // One clock edge of the model: optional step on channel sch, optional counter clear.
    task automatic model_edge(input int sch, input bit clr);
        if (clr) begin
            for (int i = 0; i < NCH; i++) mcnt[i] = 0;
        end
        if (sch >= 0) begin
            mval[sch] = (mval[sch] + 1) % (1 << VAL_W);
            if (clr) mcnt[sch] = 1;
            else if (mcnt[sch] < CMAX) mcnt[sch] = mcnt[sch] + 1;
        end
    endtask

    task automatic check_all(input logic [NCH-1:0] eevt, input bit ebusy, input bit edone);
        logic [NCH*VAL_W-1:0] ev;
        logic [NCH*CNT_W-1:0] ec;
        logic [NCH-1:0]       ef;
        for (int i = 0; i < NCH; i++) begin
            ev[i*VAL_W +: VAL_W] = VAL_W'(mval[i]);
            ec[i*CNT_W +: CNT_W] = CNT_W'(mcnt[i]);
            ef[i]                = ((mval[i] % 2) == 0);
        end
        chk("val",   64'(o_val),            64'(ev));
        chk("flag",  64'(o_flag),           64'(ef));
        chk("evt",   64'(o_evt),            64'(eevt));
        chk("cnt",   64'(o_trig_cnt),       64'(ec));
        chk("busy",  64'(o_busy),           64'(ebusy));
        chk("done",  64'(o_done),           64'(edone));
        chk("ready", 64'(cmd_if.cmd_ready), 64'(!ebusy));
    endtask

    // Junk on the command bus while busy: must neither be accepted nor alter the running command.
    task automatic drive_junk();
        cmd_if.cmd_valid = 1'($urandom_range(0, 1));
        cmd_if.cmd_ch    = 2'($urandom_range(0, 3));
        cmd_if.cmd_burst = 1'($urandom_range(0, 1));
        cmd_if.cmd_len   = 4'($urandom_range(0, 15));
        cmd_if.cmd_gap   = 3'($urandom_range(0, 7));
    endtask

    // Issue one command at a negedge while idle and check every cycle until it completes.
    // clr_edge: edge (relative to accept at 0) whose cycle drives cnt_clr; rclr adds random clears.
    task automatic run_cmd(input int ch, input bit burst, input int len, input int gap,
                           input int clr_edge, input bit rclr, output int nevt);
        int n;
        int edone;
        bit clr;
        bit stp;
        n     = burst ? len : 1;
        edone = (n == 0) ? 1 : 1 + (n - 1) * (gap + 1);
        nevt  = 0;
        obs_e.delete();
        obs_val.delete();
        obs_flag.delete();

        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 2'(ch);
        cmd_if.cmd_burst = burst;
        cmd_if.cmd_len   = 4'(len);
        cmd_if.cmd_gap   = 3'(gap);
        clr              = (clr_edge == 0) || (rclr && ($urandom_range(0, 7) == 0));
        i_cnt_clr        = clr;
        chk("ready_at_issue", 64'(cmd_if.cmd_ready), 64'd1);
        @(posedge clk);
        model_edge(-1, clr);
        @(negedge clk);
        drive_junk();
        check_all('0, 1'b1, 1'b0);

        for (int e = 1; e <= edone; e++) begin
            clr       = (clr_edge == e) || (rclr && ($urandom_range(0, 7) == 0));
            i_cnt_clr = clr;
            stp       = (n > 0) && (((e - 1) % (gap + 1)) == 0);
            @(posedge clk);
            model_edge(stp ? ch : -1, clr);
            @(negedge clk);
            if (e < edone) drive_junk();
            else cmd_if.cmd_valid = 1'b0;
            check_all(stp ? NCH'(1 << ch) : '0, e < edone, e == edone);
            if (o_evt[ch]) begin
                nevt++;
                obs_e.push_back(e);
                obs_val.push_back(int'(o_val[ch*VAL_W +: VAL_W]));
                obs_flag.push_back(int'(o_flag[ch]));
            end
        end
        i_cnt_clr        = 1'b0;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic idle_cycle(input bit rclr);
        bit clr;
        clr       = rclr && ($urandom_range(0, 5) == 0);
        i_cnt_clr = clr;
        @(posedge clk);
        model_edge(-1, clr);
        @(negedge clk);
        i_cnt_clr = 1'b0;
        check_all('0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t vecs [7];
        int   nevt;
        int   ev_seq [3];
        int   ef_seq [3];

        vecs[0] = '{ch:0, burst:0, len:0,  gap:0, exp_val:1,  exp_flag:0, exp_cnt:1,  exp_nevt:1};
        vecs[1] = '{ch:0, burst:0, len:0,  gap:0, exp_val:2,  exp_flag:1, exp_cnt:2,  exp_nevt:1};
        vecs[2] = '{ch:0, burst:0, len:0,  gap:0, exp_val:3,  exp_flag:0, exp_cnt:3,  exp_nevt:1};
        vecs[3] = '{ch:2, burst:1, len:10, gap:4, exp_val:10, exp_flag:1, exp_cnt:10, exp_nevt:10};
        vecs[4] = '{ch:3, burst:1, len:0,  gap:2, exp_val:0,  exp_flag:1, exp_cnt:0,  exp_nevt:0};
        vecs[5] = '{ch:1, burst:1, len:3,  gap:1, exp_val:3,  exp_flag:0, exp_cnt:3,  exp_nevt:3};
        vecs[6] = '{ch:1, burst:0, len:7,  gap:5, exp_val:4,  exp_flag:1, exp_cnt:4,  exp_nevt:1};

        rst              = 1'b1;
        i_cnt_clr        = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch    = '0;
        cmd_if.cmd_burst = 1'b0;
        cmd_if.cmd_len   = '0;
        cmd_if.cmd_gap   = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check_all('0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_cycle(1'b0);

        // Directed table: single steps, spaced burst, zero-length burst, len ignored on single.
        for (int v = 0; v < 7; v++) begin
            run_cmd(vecs[v].ch, vecs[v].burst, vecs[v].len, vecs[v].gap, -1, 1'b0, nevt);
            chk("tbl_val",  64'(o_val[vecs[v].ch*VAL_W +: VAL_W]),      64'(vecs[v].exp_val));
            chk("tbl_flag", 64'(o_flag[vecs[v].ch]),                    64'(vecs[v].exp_flag));
            chk("tbl_cnt",  64'(o_trig_cnt[vecs[v].ch*CNT_W +: CNT_W]), 64'(vecs[v].exp_cnt));
            chk("tbl_nevt", 64'(nevt),                                  64'(vecs[v].exp_nevt));
            if (vecs[v].exp_nevt > 1 && nevt == vecs[v].exp_nevt) begin
                for (int j = 0; j < nevt; j++) begin
                    chk("tbl_spacing", 64'(obs_e[j]), 64'(1 + j * (vecs[v].gap + 1)));
                end
            end
            idle_cycle(1'b0);
        end

        // Walk ch1 from 4 up to 0xFE, then a gapless burst across the wrap.
        for (int k = 0; k < 16; k++) run_cmd(1, 1'b1, 15, 0, -1, 1'b0, nevt);
        run_cmd(1, 1'b1, 10, 0, -1, 1'b0, nevt);
        chk("pre_wrap_val", 64'(o_val[15:8]), 64'hFE);
        run_cmd(1, 1'b1, 3, 0, -1, 1'b0, nevt);
        ev_seq = '{8'hFF, 8'h00, 8'h01};
        ef_seq = '{0, 1, 0};
        chk("wrap_nevt", 64'(nevt), 64'd3);
        if (nevt == 3) begin
            for (int j = 0; j < 3; j++) begin
                chk("wrap_val",  64'(obs_val[j]),  64'(ev_seq[j]));
                chk("wrap_flag", 64'(obs_flag[j]), 64'(ef_seq[j]));
                chk("wrap_edge", 64'(obs_e[j]),    64'(j + 1));
            end
        end

        // Counter saturation on ch3 with 20 single steps.
        for (int k = 0; k < 20; k++) run_cmd(3, 1'b0, 0, 0, -1, 1'b0, nevt);
        chk("sat_val3", 64'(o_val[31:24]),     64'd20);
        chk("sat_cnt3", 64'(o_trig_cnt[15:12]), 64'd15);

        // Clear coinciding with a step on ch1: ch1 count 1, all others 0, values untouched.
        run_cmd(1, 1'b0, 0, 0, 1, 1'b0, nevt);
        chk("clr_cnt", 64'(o_trig_cnt), 64'h0010);
        chk("clr_val", 64'(o_val),      64'h140A0203);
        idle_cycle(1'b0);

        // Randomized commands with random clears against the model.
        for (int k = 0; k < 40; k++) begin
            run_cmd($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                    $urandom_range(0, 7), -1, 1'b1, nevt);
            repeat ($urandom_range(0, 2)) idle_cycle(1'b1);
        end

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        model_edge(-1, 1'b0);
        check_all('0, 1'b0, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 2'd0;
        cmd_if.cmd_burst = 1'b1;
        cmd_if.cmd_len   = 4'd8;
        cmd_if.cmd_gap   = 3'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all('0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) idle_cycle(1'b0);
        run_cmd(0, 1'b1, 0, 0, -1, 1'b0, nevt);
        chk("rst_len0_nevt", 64'(nevt), 64'd0);
        idle_cycle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
